// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared state encodings and defaults for the program counter
package program_counter_pkg;

  typedef enum logic [1:0] {
    PC_RUN    = 2'b00,
    PC_HALTED = 2'b01,
    PC_FAULT  = 2'b10
  } pc_state_e;

  localparam int          PC_DATA_WIDTH   = 8;
  localparam int          PC_STACK_DEPTH  = 4;
  localparam int unsigned PC_RESET_VECTOR = 0;
  localparam int          NUM_PC_TEST     = 8;

  function automatic int pc_depth_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - small LIFO of return addresses with push, pop and top-replace
module pc_return_stack
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_DATA_WIDTH,
  parameter int DEPTH = PC_STACK_DEPTH
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic                             replace_i,
  input  logic [WIDTH-1:0]                 data_i,
  output logic [WIDTH-1:0]                 top_o,
  output logic [pc_depth_bits(DEPTH)-1:0]  depth_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int DW = pc_depth_bits(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [AW-1:0]    wr_idx, top_idx;

  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - DW'(1));
  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entries need no reset: only slots below depth_q are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end else if (replace_i && !empty_o) begin
      mem_q[top_idx] <= data_i;
    end
  end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - registered PC with stall, halt/resume and optional return stack (CALL_STACK_EN)
module program_counter
  import program_counter_pkg::*;
#(
  parameter int          WIDTH        = PC_DATA_WIDTH,
  parameter int unsigned RESET_VECTOR = PC_RESET_VECTOR,
  parameter int          STACK_DEPTH  = PC_STACK_DEPTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   stall_i,
  input  logic                                   take_i,
  input  logic [WIDTH-1:0]                       mux_out_i,
  input  logic                                   call_i,
  input  logic                                   ret_i,
  input  logic                                   halt_i,
  input  logic                                   resume_i,
  output logic [WIDTH-1:0]                       pc_o,
  output logic [WIDTH-1:0]                       seq_pc_o,
  output logic                                   running_o,
  output logic                                   fault_o,
  output logic [pc_depth_bits(STACK_DEPTH)-1:0]  depth_o
);

  localparam int DW = pc_depth_bits(STACK_DEPTH);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, seq_pc, stk_top;
  logic             adv, ret_en, call_en, stk_full, stk_empty;
  logic             stk_push, stk_pop, stk_replace, ret_fault, call_fault;
  logic [DW-1:0]    stk_depth;

  assign seq_pc   = pc_q + WIDTH'(1);
  assign pc_o     = pc_q;
  assign seq_pc_o = seq_pc;
  assign depth_o  = stk_depth;

`ifdef CALL_STACK_EN
  assign ret_en  = ret_i;
  assign call_en = call_i;

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (stk_push),
    .pop_i     (stk_pop),
    .replace_i (stk_replace),
    .data_i    (seq_pc),
    .top_o     (stk_top),
    .depth_o   (stk_depth),
    .full_o    (stk_full),
    .empty_o   (stk_empty)
  );
`else
  logic unused_stack;

  assign ret_en       = 1'b0;
  assign call_en      = 1'b0;
  assign stk_top      = '0;
  assign stk_depth    = '0;
  assign stk_full     = 1'b0;
  assign stk_empty    = 1'b1;
  assign unused_stack = ^{ret_i, stk_push, stk_pop, stk_replace};
`endif

  // Ret outranks Call, so a Call fault is only possible when Ret is low.
  assign adv        = (state_q == PC_RUN) && !stall_i && !halt_i;
  assign ret_fault  = adv && ret_en && stk_empty;
  assign call_fault = adv && !ret_en && call_en && stk_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PC_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PC_RUN: begin
        if (!stall_i && halt_i) begin
          state_d = PC_HALTED;
        end else if (ret_fault || call_fault) begin
          state_d = PC_FAULT;
        end
      end
      PC_HALTED: begin
        if (resume_i && !stall_i) begin
          state_d = PC_RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_replace = 1'b0;
    if (adv) begin
      if (ret_en) begin
        if (!stk_empty) begin
          pc_d        = stk_top;
          stk_replace = call_i;
          stk_pop     = !call_i;
        end
      end else if (call_en) begin
        if (!stk_full) begin
          pc_d     = mux_out_i;
          stk_push = 1'b1;
        end
      end else if (take_i || call_i) begin
        pc_d = mux_out_i;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  assign running_o = (state_q == PC_RUN);
`ifdef CALL_STACK_EN
  assign fault_o   = (state_q == PC_FAULT);
`else
  assign fault_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= WIDTH'(RESET_VECTOR);
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - table-driven directed bench for program_counter
module tb_program_counter;
  import program_counter_pkg::*;

  localparam int C_RST = 1, C_STALL = 2, C_TAKE = 4, C_CALL = 8;
  localparam int C_RET = 16, C_HALT = 32, C_RES = 64;

  typedef struct {
    string      name;
    int         ctrl;
    logic [7:0] mux;
    logic [7:0] pc;
    logic       run;
    logic       fault;
    logic [2:0] depth;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, stall, take, call, ret, halt, resume;
  logic [7:0] mux_out, pc, seq_pc;
  logic       running, fault;
  logic [2:0] depth;

  int   passed = 0;
  int   total  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  program_counter #(
    .WIDTH        (8),
    .RESET_VECTOR (0),
    .STACK_DEPTH  (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .stall_i   (stall),
    .take_i    (take),
    .mux_out_i (mux_out),
    .call_i    (call),
    .ret_i     (ret),
    .halt_i    (halt),
    .resume_i  (resume),
    .pc_o      (pc),
    .seq_pc_o  (seq_pc),
    .running_o (running),
    .fault_o   (fault),
    .depth_o   (depth)
  );

  task automatic add(input string n, input int c, input logic [7:0] m, input logic [7:0] p,
                     input logic r, input logic f, input logic [2:0] d);
    vec_t v;
    v.name = n; v.ctrl = c; v.mux = m; v.pc = p; v.run = r; v.fault = f; v.depth = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string what, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", what, act, exp);
  endtask

  initial begin
    {rst, stall, take, call, ret, halt, resume} = '0;
    mux_out = '0;

    add("reset",      C_RST,            8'h00, 8'h00, 1, 0, 0);
    add("seq1",       0,                8'h00, 8'h01, 1, 0, 0);
    add("seq2",       0,                8'h00, 8'h02, 1, 0, 0);
    add("seq3",       0,                8'h00, 8'h03, 1, 0, 0);
    add("take5",      C_TAKE,           8'h05, 8'h05, 1, 0, 0);
    add("stall_take", C_STALL | C_TAKE, 8'h40, 8'h05, 1, 0, 0);
    add("take40",     C_TAKE,           8'h40, 8'h40, 1, 0, 0);
    add("take10",     C_TAKE,           8'h10, 8'h10, 1, 0, 0);
`ifdef CALL_STACK_EN
    add("call80",     C_CALL,           8'h80, 8'h80, 1, 0, 1);
    add("take85",     C_TAKE,           8'h85, 8'h85, 1, 0, 1);
    add("ret",        C_RET,            8'h00, 8'h11, 1, 0, 0);
    add("ret_empty",  C_RET,            8'h00, 8'h11, 0, 1, 0);
    add("fault_res",  C_RES | C_TAKE,   8'h22, 8'h11, 0, 1, 0);
    add("rst_fault",  C_RST,            8'h00, 8'h00, 1, 0, 0);
    add("call20",     C_CALL,           8'h20, 8'h20, 1, 0, 1);
    add("call30",     C_CALL,           8'h30, 8'h30, 1, 0, 2);
    add("call40",     C_CALL,           8'h40, 8'h40, 1, 0, 3);
    add("call50",     C_CALL,           8'h50, 8'h50, 1, 0, 4);
    add("call_full",  C_CALL,           8'h60, 8'h50, 0, 1, 4);
    add("full_res",   C_RES,            8'h00, 8'h50, 0, 1, 4);
    add("rst_full",   C_RST | C_STALL,  8'h00, 8'h00, 1, 0, 0);
    add("call90",     C_CALL,           8'h90, 8'h90, 1, 0, 1);
    add("call_ret",   C_CALL | C_RET,   8'h33, 8'h01, 1, 0, 1);
    add("ret_repl",   C_RET,            8'h00, 8'h91, 1, 0, 0);
`else
    add("call30",     C_CALL,           8'h30, 8'h30, 1, 0, 0);
    add("ret_ign",    C_RET,            8'h00, 8'h31, 1, 0, 0);
    add("call_ret",   C_CALL | C_RET,   8'h44, 8'h44, 1, 0, 0);
    add("res_run",    C_RES,            8'h00, 8'h45, 1, 0, 0);
`endif
    add("takeFF",     C_TAKE,           8'hFF, 8'hFF, 1, 0, 0);
    add("wrap",       0,                8'h00, 8'h00, 1, 0, 0);
    add("take7",      C_TAKE,           8'h07, 8'h07, 1, 0, 0);
    add("halt",       C_HALT,           8'h00, 8'h07, 0, 0, 0);
    add("h_take",     C_TAKE,           8'h55, 8'h07, 0, 0, 0);
    add("h_call",     C_CALL | C_TAKE,  8'h66, 8'h07, 0, 0, 0);
    add("h_ret",      C_RET,            8'h00, 8'h07, 0, 0, 0);
    add("h_stall_res",C_STALL | C_RES,  8'h00, 8'h07, 0, 0, 0);
    add("resume",     C_RES,            8'h00, 8'h07, 1, 0, 0);
    add("after_res",  0,                8'h00, 8'h08, 1, 0, 0);
    add("stall_halt", C_STALL | C_HALT, 8'h00, 8'h08, 1, 0, 0);
    add("halt_take",  C_HALT | C_TAKE,  8'h99, 8'h08, 0, 0, 0);
    add("resume2",    C_RES,            8'h00, 8'h08, 1, 0, 0);
    add("after_res2", 0,                8'h00, 8'h09, 1, 0, 0);
    add("takeFF2",    C_TAKE,           8'hFF, 8'hFF, 1, 0, 0);
`ifdef CALL_STACK_EN
    add("call_wrap",  C_CALL,           8'h10, 8'h10, 1, 0, 1);
    add("ret_wrap",   C_RET,            8'h00, 8'h00, 1, 0, 0);
    add("halt2",      C_HALT,           8'h00, 8'h00, 0, 0, 0);
`else
    add("call_take",  C_CALL,           8'h10, 8'h10, 1, 0, 0);
    add("ret_ign2",   C_RET,            8'h00, 8'h11, 1, 0, 0);
    add("halt2",      C_HALT,           8'h00, 8'h11, 0, 0, 0);
`endif
    add("rst_halt",   C_RST | C_STALL | C_HALT, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 1; i <= NUM_PC_TEST; i++) add("free_run", 0, 8'h00, 8'(i), 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst     = (vecs[i].ctrl & C_RST)   != 0;
      stall   = (vecs[i].ctrl & C_STALL) != 0;
      take    = (vecs[i].ctrl & C_TAKE)  != 0;
      call    = (vecs[i].ctrl & C_CALL)  != 0;
      ret     = (vecs[i].ctrl & C_RET)   != 0;
      halt    = (vecs[i].ctrl & C_HALT)  != 0;
      resume  = (vecs[i].ctrl & C_RES)   != 0;
      mux_out = vecs[i].mux;
      @(posedge clk);
      #1;
      check({vecs[i].name, ".pc"},      int'(pc),      int'(vecs[i].pc));
      check({vecs[i].name, ".seq_pc"},  int'(seq_pc),  int'(8'(vecs[i].pc + 8'd1)));
      check({vecs[i].name, ".running"}, int'(running), int'(vecs[i].run));
      check({vecs[i].name, ".fault"},   int'(fault),   int'(vecs[i].fault));
      check({vecs[i].name, ".depth"},   int'(depth),   int'(vecs[i].depth));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
